// File: rtl/cache_wtbuf_drain_axi_pkg.sv
// rtl/cache_wtbuf_drain_axi_pkg.sv - shared types and constants for the write-through buffer drain
package cache_wtbuf_drain_axi_pkg;

  // Default cache geometry; the top-level parameters take these as defaults.
  localparam int CACHE_FRONTEND_ADDR_W = 32;
  localparam int CACHE_FRONTEND_DATA_W = 32;
  localparam int CACHE_BACKEND_DATA_W  = 512;
  localparam int CACHE_AXI_ADDR_W      = 32;
  localparam int CACHE_AXI_ID_W        = 4;
  localparam int CACHE_WTBUF_DEPTH_W   = 5;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  // Modifiable, bufferable: the backend may merge or delay write-through traffic.
  localparam logic [3:0] AXI_CACHE_WTBUF = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2
  } cache_wtbuf_drain_state_t;

  // Buffered frontend write at the default geometry.
  typedef struct packed {
    logic [CACHE_FRONTEND_ADDR_W-1:0]   addr;
    logic [CACHE_FRONTEND_DATA_W-1:0]   data;
    logic [CACHE_FRONTEND_DATA_W/8-1:0] strb;
  } cache_wtbuf_entry_t;

  // AXI AxSIZE encoding for a beat of the given byte count.
  function automatic logic [2:0] axi_size(input int bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/cache_wtbuf_drain_axi_wtbuf_fifo.sv
// rtl/cache_wtbuf_drain_axi_wtbuf_fifo.sv - synchronous FIFO holding buffered write-through entries
module wtbuf_fifo
  import cache_wtbuf_drain_axi_pkg::*;
#(
  parameter int  DEPTH_W = CACHE_WTBUF_DEPTH_W,
  parameter type entry_t = cache_wtbuf_entry_t
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  entry_t             push_entry_i,
  input  logic               pop_i,
  output entry_t             head_o,
  output logic [DEPTH_W:0]   count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int DEPTH = 2 ** DEPTH_W;

  entry_t               mem_q [DEPTH];
  logic [DEPTH_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W:0]     count_q, count_d;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == (DEPTH_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Overflow and underflow requests are dropped here so callers need not guard them.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next pointer/count state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards all buffered entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/cache_wtbuf_drain_axi.sv
// rtl/cache_wtbuf_drain_axi.sv - drains the write-through buffer as single-beat AXI4 writes
module cache_wtbuf_drain_axi
  import cache_wtbuf_drain_axi_pkg::*;
#(
  parameter int FRONT_ADDR_W = CACHE_FRONTEND_ADDR_W,
  parameter int FRONT_DATA_W = CACHE_FRONTEND_DATA_W,
  parameter int BACK_DATA_W  = CACHE_BACKEND_DATA_W,
  parameter int AXI_ADDR_W   = CACHE_AXI_ADDR_W,
  parameter int AXI_ID_W     = CACHE_AXI_ID_W,
  parameter int DEPTH_W      = CACHE_WTBUF_DEPTH_W,
  parameter logic [AXI_ID_W-1:0] CACHE_AXI_ID = '0
) (
  input  logic                       ap_clk,
  input  logic                       areset,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [FRONT_ADDR_W-1:0]    push_addr,
  input  logic [FRONT_DATA_W-1:0]    push_data,
  input  logic [FRONT_DATA_W/8-1:0]  push_strb,
  output logic                       wtb_empty,
  output logic                       wtb_full,
  output logic                       write_error,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [AXI_ADDR_W-1:0]      m_axi_awaddr,
  output logic [AXI_ID_W-1:0]        m_axi_awid,
  output logic [7:0]                 m_axi_awlen,
  output logic [2:0]                 m_axi_awsize,
  output logic [1:0]                 m_axi_awburst,
  output logic [3:0]                 m_axi_awcache,
  output logic [2:0]                 m_axi_awprot,
  output logic                       m_axi_awlock,
  output logic [3:0]                 m_axi_awqos,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  output logic [BACK_DATA_W-1:0]     m_axi_wdata,
  output logic [BACK_DATA_W/8-1:0]   m_axi_wstrb,
  output logic                       m_axi_wlast,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready,
  input  logic [1:0]                 m_axi_bresp,
  input  logic [AXI_ID_W-1:0]        m_axi_bid
);

  localparam int FRONT_BYTES  = FRONT_DATA_W / 8;
  localparam int BACK_BYTES   = BACK_DATA_W / 8;
  localparam int FRONT_BYTE_W = $clog2(FRONT_BYTES);
  localparam int BACK_BYTE_W  = $clog2(BACK_BYTES);
  localparam int LANE_W       = BACK_BYTE_W - FRONT_BYTE_W;
  localparam int LANES        = BACK_DATA_W / FRONT_DATA_W;

  typedef struct packed {
    logic [FRONT_ADDR_W-1:0] addr;
    logic [FRONT_DATA_W-1:0] data;
    logic [FRONT_BYTES-1:0]  strb;
  } wtb_entry_t;

  wtb_entry_t               push_entry, head;
  logic [DEPTH_W:0]         fifo_count;
  logic                     fifo_full, fifo_empty, fifo_pop;

  cache_wtbuf_drain_state_t state_q;
  logic                     awvalid_q, wvalid_q, bready_q, write_error_q;
  logic [AXI_ADDR_W-1:0]    awaddr_q, awaddr_d;
  logic [BACK_DATA_W-1:0]   wdata_q, wdata_d;
  logic [BACK_BYTES-1:0]    wstrb_q, wstrb_d;
  logic [31:0]              strb_shift;
  logic                     aw_done, w_done;
  logic                     unused_bid;

  assign push_entry = '{addr: push_addr, data: push_data, strb: push_strb};

  wtbuf_fifo #(
    .DEPTH_W (DEPTH_W),
    .entry_t (wtb_entry_t)
  ) u_fifo (
    .clk          (ap_clk),
    .rst          (areset),
    .push_i       (push_valid),
    .push_entry_i (push_entry),
    .pop_i        (fifo_pop),
    .head_o       (head),
    .count_o      (fifo_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  // The head entry leaves the buffer only once its write response has been taken.
  assign fifo_pop = (state_q == RESP) & bready_q & m_axi_bvalid;

  // Byte offset of the frontend word inside the backend beat; zero when the widths match.
  if (LANE_W > 0) begin : g_lane
    always_comb strb_shift = 32'(head.addr[BACK_BYTE_W-1:FRONT_BYTE_W]) * 32'(FRONT_BYTES);
  end else begin : g_no_lane
    assign strb_shift = '0;
  end

  // Map the head entry onto a full backend beat: aligned address, replicated data, shifted strobes.
  always_comb begin
    awaddr_d = AXI_ADDR_W'(head.addr & ~FRONT_ADDR_W'(BACK_BYTES - 1));
    wdata_d  = {LANES{head.data}};
    wstrb_d  = BACK_BYTES'(head.strb) << strb_shift;
  end

  // In SEND a channel's valid doubles as its not-done flag, so each channel completes independently.
  assign aw_done = ~awvalid_q | m_axi_awready;
  assign w_done  = ~wvalid_q  | m_axi_wready;

  // Drain FSM with one write outstanding; all AXI-facing controls are registered.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q       <= IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      write_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (m_axi_awready) awvalid_q <= 1'b0;
          if (m_axi_wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        RESP: begin
          if (m_axi_bvalid) begin
            bready_q <= 1'b0;
            state_q  <= IDLE;
            // Errors are recorded but never block further draining.
            if (m_axi_bresp != AXI_RESP_OKAY) write_error_q <= 1'b1;
          end
        end
        default: begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign push_ready    = ~fifo_full;
  assign wtb_full      = fifo_full;
  assign wtb_empty     = (fifo_count == '0) & (state_q == IDLE);
  assign write_error   = write_error_q;

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awid    = CACHE_AXI_ID;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = axi_size(BACK_BYTES);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awcache = AXI_CACHE_WTBUF;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_bready  = bready_q;

  // Only one write is ever outstanding, so the response ID carries no information.
  assign unused_bid = ^m_axi_bid;

endmodule

// File: tb/tb_cache_wtbuf_drain_axi.sv
// tb/tb_cache_wtbuf_drain_axi.sv - scoreboard bench for the write-through buffer drain
module tb_cache_wtbuf_drain_axi;

  logic         ap_clk = 1'b0;
  logic         areset;
  logic         push_valid, push_ready;
  logic [31:0]  push_addr, push_data;
  logic [3:0]   push_strb;
  logic         wtb_empty, wtb_full, write_error;
  logic         m_axi_awvalid, m_axi_awready;
  logic [31:0]  m_axi_awaddr;
  logic [3:0]   m_axi_awid;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic [3:0]   m_axi_awcache;
  logic [2:0]   m_axi_awprot;
  logic         m_axi_awlock;
  logic [3:0]   m_axi_awqos;
  logic         m_axi_wvalid, m_axi_wready;
  logic [511:0] m_axi_wdata;
  logic [63:0]  m_axi_wstrb;
  logic         m_axi_wlast;
  logic         m_axi_bvalid, m_axi_bready;
  logic [1:0]   m_axi_bresp;
  logic [3:0]   m_axi_bid;

  always #5 ap_clk = ~ap_clk;

  cache_wtbuf_drain_axi #(
    .FRONT_ADDR_W (32), .FRONT_DATA_W (32), .BACK_DATA_W (512),
    .AXI_ADDR_W (32), .AXI_ID_W (4), .DEPTH_W (5), .CACHE_AXI_ID (4'h0)
  ) dut (
    .ap_clk (ap_clk), .areset (areset),
    .push_valid (push_valid), .push_ready (push_ready),
    .push_addr (push_addr), .push_data (push_data), .push_strb (push_strb),
    .wtb_empty (wtb_empty), .wtb_full (wtb_full), .write_error (write_error),
    .m_axi_awvalid (m_axi_awvalid), .m_axi_awready (m_axi_awready),
    .m_axi_awaddr (m_axi_awaddr), .m_axi_awid (m_axi_awid), .m_axi_awlen (m_axi_awlen),
    .m_axi_awsize (m_axi_awsize), .m_axi_awburst (m_axi_awburst), .m_axi_awcache (m_axi_awcache),
    .m_axi_awprot (m_axi_awprot), .m_axi_awlock (m_axi_awlock), .m_axi_awqos (m_axi_awqos),
    .m_axi_wvalid (m_axi_wvalid), .m_axi_wready (m_axi_wready),
    .m_axi_wdata (m_axi_wdata), .m_axi_wstrb (m_axi_wstrb), .m_axi_wlast (m_axi_wlast),
    .m_axi_bvalid (m_axi_bvalid), .m_axi_bready (m_axi_bready),
    .m_axi_bresp (m_axi_bresp), .m_axi_bid (m_axi_bid)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [63:0]  strb;
    logic [511:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] resp_q[$];
  int         checks = 0;
  int         errors = 0;

  // Knobs written by the stimulus, counters written by the AXI slave.
  int         aw_stall_cfg = 0;
  bit         b_stall = 1'b0;
  int         aw_stall_cycles = 0;
  int         w_valid_cycles = 0;
  int         b_count = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t        e;
    logic [63:0] st;
    st     = 64'(s);
    e.addr = a & 32'hFFFF_FFC0;
    e.strb = st << (a[5:2] * 4);
    e.data = {16{d}};
    return e;
  endfunction

  // AXI slave: acts at the falling edge, compares each completed AW+W pair against the scoreboard.
  initial begin : axi_slave
    bit           aw_seen, w_seen, b_pending;
    int           aw_run;
    logic [31:0]  got_addr;
    logic [63:0]  got_strb;
    logic [511:0] got_data;
    exp_t         e;
    aw_seen = 0; w_seen = 0; b_pending = 0; aw_run = 0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_bresp = 2'b00; m_axi_bid = 4'h0;
    forever begin
      @(negedge ap_clk);
      if (areset) begin
        aw_seen = 0; w_seen = 0; b_pending = 0; aw_run = 0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
      end else begin
        m_axi_bvalid = b_pending && !b_stall;
        m_axi_bresp  = (resp_q.size() != 0) ? resp_q[0] : 2'b00;
        if (m_axi_bvalid && m_axi_bready) begin
          b_count++;
          b_pending = 0;
          if (resp_q.size() != 0) void'(resp_q.pop_front());
        end
        m_axi_awready = (aw_run >= aw_stall_cfg);
        if (m_axi_awvalid) begin
          if (!m_axi_awready) begin
            aw_run++;
            aw_stall_cycles++;
          end else begin
            aw_run   = 0;
            aw_seen  = 1;
            got_addr = m_axi_awaddr;
            check("aw_fixed_fields",
                  {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awprot, m_axi_awlock, m_axi_awqos, m_axi_awid},
                  {8'h00, 3'd6, 2'b01, 4'b0011, 3'b000, 1'b0, 4'h0, 4'h0});
          end
        end
        m_axi_wready = 1'b1;
        if (m_axi_wvalid) begin
          w_valid_cycles++;
          w_seen   = 1;
          got_data = m_axi_wdata;
          got_strb = m_axi_wstrb;
          check("wlast", m_axi_wlast, 1'b1);
        end
        if (aw_seen && w_seen) begin
          check("sb_has_entry", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("awaddr", got_addr, e.addr);
            check("wstrb", got_strb, e.strb);
            check("wdata", got_data, e.data);
          end
          aw_seen = 0; w_seen = 0; b_pending = 1;
        end
      end
    end
  end

  // Called just after a falling edge; holds the request until accepted.
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok;
    ok = 0;
    push_valid = 1'b1; push_addr = a; push_data = d; push_strb = s;
    for (int i = 0; i < 300; i++) begin
      if (push_ready) begin
        exp_q.push_back(model(a, d, s));
        ok = 1;
        @(negedge ap_clk); #1;
        break;
      end
      @(negedge ap_clk); #1;
    end
    push_valid = 1'b0;
    check("push_accepted", ok, 1'b1);
  endtask

  task automatic wait_drain(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge ap_clk); #1;
      if (wtb_empty && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic wait_b(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge ap_clk); #1;
      if (m_axi_bvalid && m_axi_bready) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin : stimulus
    bit ok;
    int b0, aw0, w0;
    areset = 1'b1; push_valid = 1'b0; push_addr = '0; push_data = '0; push_strb = '0;
    repeat (3) @(negedge ap_clk);
    #1;
    check("reset_outputs",
          {m_axi_awvalid, m_axi_wvalid, m_axi_bready, push_ready, wtb_empty, wtb_full, write_error},
          7'b0001100);
    check("reset_count", dut.fifo_count, 6'd0);
    areset = 1'b0;

    // Single write: lane mapping, replication, latency, flush-done timing.
    @(negedge ap_clk); #1;
    push_valid = 1'b1; push_addr = 32'h44; push_data = 32'hDEADBEEF; push_strb = 4'hF;
    exp_q.push_back(model(32'h44, 32'hDEADBEEF, 4'hF));
    @(posedge ap_clk); #1;
    push_valid = 1'b0;
    check("t1_valids_after_push_edge", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
    @(posedge ap_clk); #1;
    check("t1_valids_next_edge", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    check("t1_not_empty", wtb_empty, 1'b0);
    wait_b(ok);
    check("t1_b_seen", ok, 1'b1);
    check("t1_empty_before_b", wtb_empty, 1'b0);
    @(posedge ap_clk); #1;
    check("t1_empty_after_b", wtb_empty, 1'b1);

    // AW stalled five cycles while W is accepted at once.
    @(negedge ap_clk); #1;
    aw_stall_cfg = 5;
    b0 = b_count; aw0 = aw_stall_cycles; w0 = w_valid_cycles;
    push(32'h0000_1008, 32'h1234_5678, 4'h3);
    wait_drain("t3_drain");
    check("t3_aw_stall_cycles", aw_stall_cycles - aw0, 5);
    check("t3_w_valid_cycles", w_valid_cycles - w0, 1);
    check("t3_b_count", b_count - b0, 1);
    check("t3_fifo_count", dut.fifo_count, 6'd0);
    aw_stall_cfg = 0;

    // Error response on the second of three writes.
    b0 = b_count;
    resp_q.push_back(2'b00); resp_q.push_back(2'b10); resp_q.push_back(2'b00);
    push(32'h0000_3000, 32'hA0A0_0001, 4'hF);
    push(32'h0000_303C, 32'hA0A0_0002, 4'h8);
    push(32'h0000_3104, 32'hA0A0_0003, 4'h6);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge ap_clk); #1;
      if (m_axi_bvalid && m_axi_bready && m_axi_bresp == 2'b10) begin
        ok = 1;
        check("t4_error_before_b", write_error, 1'b0);
        @(posedge ap_clk); #1;
        check("t4_error_after_b", write_error, 1'b1);
        break;
      end
    end
    check("t4_err_b_seen", ok, 1'b1);
    wait_drain("t4_drain");
    check("t4_error_sticky", write_error, 1'b1);
    check("t4_b_count", b_count - b0, 3);

    // Responses stalled: fill all 32 entries, hold the 33rd, then release.
    b_stall = 1'b1;
    b0 = b_count;
    for (int i = 0; i < 32; i++)
      push(32'h0000_2000 + 32'(i * 4), $urandom, 4'((i % 15) + 1));
    check("t2_full", {wtb_full, push_ready}, 2'b10);
    check("t2_count_full", dut.fifo_count, 6'd32);
    push_valid = 1'b1; push_addr = 32'h0000_2F80; push_data = 32'h3333_3333; push_strb = 4'hC;
    repeat (3) begin @(negedge ap_clk); #1; end
    check("t2_33rd_held", push_ready, 1'b0);
    check("t2_no_b_yet", b_count - b0, 0);
    b_stall = 1'b0;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge ap_clk); #1;
      if (push_ready) begin
        ok = 1;
        exp_q.push_back(model(32'h0000_2F80, 32'h3333_3333, 4'hC));
        check("t2_accept_after_first_pop", b_count - b0, 1);
        @(negedge ap_clk); #1;
        break;
      end
    end
    push_valid = 1'b0;
    check("t2_33rd_accepted", ok, 1'b1);
    wait_drain("t2_drain");
    check("t2_b_count", b_count - b0, 33);

    // Push coinciding with a pop at count 5.
    b_stall = 1'b1;
    for (int i = 0; i < 5; i++)
      push(32'h0000_5000 + 32'(i * 64), 32'h5500_0000 + 32'(i), 4'hF);
    check("t6_count_before", dut.fifo_count, 6'd5);
    b_stall = 1'b0;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge ap_clk); #1;
      if (m_axi_bvalid && m_axi_bready) begin
        ok = 1;
        push_valid = 1'b1; push_addr = 32'h0000_5A10; push_data = 32'h6666_6666; push_strb = 4'h1;
        exp_q.push_back(model(32'h0000_5A10, 32'h6666_6666, 4'h1));
        @(posedge ap_clk); #1;
        push_valid = 1'b0;
        check("t6_count_unchanged", dut.fifo_count, 6'd5);
        check("t6_not_full", wtb_full, 1'b0);
        break;
      end
    end
    check("t6_b_seen", ok, 1'b1);
    wait_drain("t6_drain");

    // Reset while waiting for a response with four entries queued.
    b_stall = 1'b1;
    for (int i = 0; i < 4; i++)
      push(32'h0000_7000 + 32'(i * 4), 32'h7700_0000 + 32'(i), 4'hF);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ap_clk); #1;
      if (m_axi_bready) begin
        ok = 1;
        break;
      end
    end
    check("t5_in_resp", ok, 1'b1);
    areset = 1'b1;
    exp_q.delete();
    resp_q.delete();
    #1;
    check("t5_valids_in_reset", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b000);
    check("t5_flags_in_reset", {wtb_empty, push_ready, wtb_full}, 3'b110);
    check("t5_count_in_reset", dut.fifo_count, 6'd0);
    @(negedge ap_clk); #1;
    areset = 1'b0;
    b_stall = 1'b0;
    repeat (5) begin @(negedge ap_clk); #1; end
    check("t5_after_release", {write_error, wtb_empty, push_ready, m_axi_awvalid, m_axi_wvalid}, 5'b01100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
